// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared receive-side constants: COM symbol and sync FSM encoding
package phy_rx_pkg;

  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    LOSS_SYNC = 2'd0,
    ALIGN     = 2'd1,
    IN_SYNC   = 2'd2
  } state_t;

endpackage

// File: rtl/unstrip_ctrl_com_detect.sv
// rtl/unstrip_ctrl_com_detect.sv - flags a qualified COM byte on the unstriped stream
module com_detect
  import phy_rx_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       is_com
);

  assign is_com = valid_in && (data_in == COM);

endmodule

// File: rtl/unstrip_ctrl.sv
// rtl/unstrip_ctrl.sv - COM-based sync FSM, lane tagging and payload forwarding; UNSTRIP_CTRL_ERRCNT_EN adds err_cnt
module unstrip_ctrl
  import phy_rx_pkg::*;
#(
  parameter int COM_NEEDED = 4,
  parameter int MAX_GAP    = 16
) (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       active
`ifdef UNSTRIP_CTRL_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int CW = $clog2(COM_NEEDED + 1);
  localparam int GW = $clog2(MAX_GAP + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] com_cnt, com_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          lane_sel, lane_nxt;
  logic          is_com;
  logic          fwd;
  logic          sync_lost;

  com_detect u_com_detect (
    .data_in  (data_in),
    .valid_in (valid_in),
    .is_com   (is_com)
  );

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= LOSS_SYNC;
      com_cnt  <= '0;
      gap_cnt  <= '0;
      lane_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      com_cnt  <= com_nxt;
      gap_cnt  <= gap_nxt;
      lane_sel <= lane_nxt;
    end
  end

  // Idle cycles (valid_in=0) fall through every branch with all state held.
  always_comb begin
    state_nxt = state;
    com_nxt   = com_cnt;
    gap_nxt   = gap_cnt;
    lane_nxt  = lane_sel;
    case (state)
      LOSS_SYNC: begin
        if (is_com) begin
          com_nxt = CW'(1);
          if (COM_NEEDED <= 1) begin
            state_nxt = IN_SYNC;
            gap_nxt   = '0;
            lane_nxt  = 1'b0;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (is_com) begin
          if (com_cnt >= CW'(COM_NEEDED - 1)) begin
            com_nxt   = CW'(COM_NEEDED);
            state_nxt = IN_SYNC;
            gap_nxt   = '0;
            lane_nxt  = 1'b0;
          end else begin
            com_nxt = com_cnt + CW'(1);
          end
        end else if (valid_in) begin
          state_nxt = LOSS_SYNC;
          com_nxt   = '0;
        end
      end
      IN_SYNC: begin
        if (is_com) begin
          gap_nxt  = '0;
          lane_nxt = 1'b0;
        end else if (valid_in) begin
          if (gap_cnt == GW'(MAX_GAP)) begin
            state_nxt = LOSS_SYNC;
            com_nxt   = '0;
          end else begin
            gap_nxt  = gap_cnt + GW'(1);
            lane_nxt = ~lane_sel;
          end
        end
      end
      default: begin
        state_nxt = LOSS_SYNC;
        com_nxt   = '0;
        gap_nxt   = '0;
        lane_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    fwd       = (state == IN_SYNC) && valid_in && !is_com && (gap_cnt != GW'(MAX_GAP));
    sync_lost = (state == IN_SYNC) && (state_nxt == LOSS_SYNC);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      lane_out  <= 1'b0;
      active    <= 1'b0;
    end else begin
      valid_out <= fwd;
      active    <= (state_nxt == IN_SYNC);
      if (fwd) begin
        data_out <= data_in;
        lane_out <= lane_sel;
      end
    end
  end

`ifdef UNSTRIP_CTRL_ERRCNT_EN
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      err_cnt <= 8'h00;
    end else if (sync_lost && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  logic unused_sync_lost;
  assign unused_sync_lost = sync_lost;
`endif

endmodule

// File: tb/tb_unstrip_ctrl.sv
// tb/tb_unstrip_ctrl.sv - directed self-checking bench for unstrip_ctrl; honours UNSTRIP_CTRL_ERRCNT_EN
module tb_unstrip_ctrl;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic       active;
`ifdef UNSTRIP_CTRL_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  unstrip_ctrl dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .active    (active)
`ifdef UNSTRIP_CTRL_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one input cycle, then sample just after the capturing edge.
  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic sync_up(input string tag);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hBC);
      check({tag, "_align_vout"}, 32'(valid_out), 32'd0);
      check({tag, "_align_active"}, 32'(active), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic expect_fwd(input string tag, input logic [7:0] d, input logic lane);
    step(1'b1, d);
    check({tag, "_vout"}, 32'(valid_out), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(d));
    check({tag, "_lane"}, 32'(lane_out), 32'(lane));
  endtask

  initial begin
    #1;
    check("rst_vout", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_lane", 32'(lane_out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
`ifdef UNSTRIP_CTRL_ERRCNT_EN
    check("rst_err", 32'(err_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk_2f);
    #1;
    reset_L = 1'b1;

    sync_up("sync1");

    expect_fwd("b11", 8'h11, 1'b0);
    expect_fwd("b22", 8'h22, 1'b1);
    expect_fwd("b33", 8'h33, 1'b0);
    step(1'b0, 8'hEE);
    check("idle_vout", 32'(valid_out), 32'd0);
    check("idle_data_hold", 32'(data_out), 32'h33);
    check("idle_lane_hold", 32'(lane_out), 32'd0);
    check("idle_active", 32'(active), 32'd1);

    // lane_sel is 1 here; a COM forces it back to 0
    step(1'b1, 8'hBC);
    check("com_drop_vout", 32'(valid_out), 32'd0);
    expect_fwd("c11", 8'h11, 1'b0);
    step(1'b1, 8'hBC);
    check("com_mid_vout", 32'(valid_out), 32'd0);
    check("com_mid_data_hold", 32'(data_out), 32'h11);
    expect_fwd("c22", 8'h22, 1'b0);

    // valid_in gap holds lane_sel
    step(1'b1, 8'hBC);
    expect_fwd("g11", 8'h11, 1'b0);
    step(1'b0, 8'h00);
    check("gap_vout", 32'(valid_out), 32'd0);
    expect_fwd("g22", 8'h22, 1'b1);

    // 16 forwarded, 17th dropped
    step(1'b1, 8'hBC);
    for (int i = 0; i < 16; i++) begin
      expect_fwd($sformatf("run%0d", i), 8'(i + 1), 1'(i % 2));
    end
    check("run16_active", 32'(active), 32'd1);
    step(1'b1, 8'h77);
    check("run17_vout", 32'(valid_out), 32'd0);
    check("run17_active", 32'(active), 32'd0);
    check("run17_data_hold", 32'(data_out), 32'h10);
`ifdef UNSTRIP_CTRL_ERRCNT_EN
    check("run17_err", 32'(err_cnt), 32'd1);
`endif
    step(1'b1, 8'h66);
    check("loss_vout", 32'(valid_out), 32'd0);

    // ALIGN aborted by non-COM needs a full fresh COM run
    step(1'b1, 8'hBC);
    step(1'b1, 8'hBC);
    check("align2_active", 32'(active), 32'd0);
    step(1'b1, 8'h55);
    check("abort_vout", 32'(valid_out), 32'd0);
    check("abort_active", 32'(active), 32'd0);
    sync_up("sync2");

    // asynchronous mid-stream reset
    expect_fwd("pre_rst", 8'h77, 1'b0);
    valid_in = 1'b1;
    data_in  = 8'h99;
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_vout", 32'(valid_out), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    check("arst_lane", 32'(lane_out), 32'd0);
    check("arst_active", 32'(active), 32'd0);
`ifdef UNSTRIP_CTRL_ERRCNT_EN
    check("arst_err", 32'(err_cnt), 32'd0);
`endif
    @(posedge clk_2f);
    #1;
    valid_in = 1'b0;
    reset_L  = 1'b1;
    step(1'b1, 8'h42);
    check("post_rst_vout", 32'(valid_out), 32'd0);
    check("post_rst_active", 32'(active), 32'd0);
    sync_up("sync3");
    expect_fwd("post_sync", 8'hA5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/unstrip_ctrl.md
UNSTRIP_CTRL -- requirements
Module: unstrip_ctrl

Interface
REQ-001 Parameter COM_NEEDED, default 4, number of consecutive valid COM bytes needed to reach sync.
REQ-002 Parameter MAX_GAP, default 16, maximum valid non-COM bytes allowed between two COM bytes.
REQ-003 Port clk_2f, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset_L, input, 1, asynchronous active-low reset.
REQ-005 Port data_in, input, 8, byte stream from the unstriping path.
REQ-006 Port valid_in, input, 1, data_in qualifier.
REQ-007 Port data_out, output, 8, forwarded payload byte, registered.
REQ-008 Port valid_out, output, 1, data_out qualifier, registered.
REQ-009 Port lane_out, output, 1, demux lane (0/1) the forwarded byte belongs to, registered.
REQ-010 Port active, output, 1, high while in IN_SYNC, registered.

Function
REQ-011 The FSM SHALL have states LOSS_SYNC, ALIGN and IN_SYNC; COM is byte 0xBC.
REQ-012 In LOSS_SYNC, valid COM SHALL go to ALIGN with com_cnt=1; anything else holds.
REQ-013 In ALIGN, valid COM SHALL increment com_cnt and go to IN_SYNC with lane_sel=0 and gap_cnt=0 when com_cnt reaches COM_NEEDED.
REQ-014 In ALIGN, valid non-COM SHALL go to LOSS_SYNC and clear com_cnt.
REQ-015 In IN_SYNC, valid COM SHALL be consumed (valid_out=0), clear gap_cnt and force lane_sel=0.
REQ-016 In IN_SYNC, valid non-COM with gap_cnt<MAX_GAP SHALL drive data_out=data_in, valid_out=1 and lane_out=lane_sel on the next edge, then toggle lane_sel and increment gap_cnt.
REQ-017 In IN_SYNC, valid non-COM with gap_cnt==MAX_GAP SHALL be dropped, valid_out=0, and go to LOSS_SYNC.
REQ-018 valid_in=0 in any state SHALL hold state, com_cnt, gap_cnt and lane_sel; valid_out=0 on the next edge.
REQ-019 data_out and lane_out SHALL hold their last values whenever valid_out=0.
REQ-020 Latency SHALL be one clk_2f cycle from input to valid_out.
REQ-021 active SHALL equal (state==IN_SYNC) one cycle delayed, i.e. registered alongside the state.
REQ-022 Counters SHALL be sized to the parameter ranges and never wrap: com_cnt saturates at COM_NEEDED, gap_cnt at MAX_GAP.

Reset
REQ-023 reset_L=0 SHALL immediately clear data_out, valid_out, lane_out, active, com_cnt, gap_cnt and lane_sel to 0, and set the state to LOSS_SYNC, regardless of the clock.
REQ-024 Reset asserted mid-stream SHALL drop any in-flight byte; after release, sync requires a fresh COM_NEEDED COM bytes.

Configuration
REQ-025 With macro UNSTRIP_CTRL_ERRCNT_EN defined, the block SHALL add output err_cnt[7:0] (reset 0), incrementing by one on every IN_SYNC-to-LOSS_SYNC transition and saturating at 255.
REQ-026 Without UNSTRIP_CTRL_ERRCNT_EN, port err_cnt and its logic SHALL be absent.

Structure
REQ-027 A shared package phy_rx_pkg SHALL hold the COM constant (8'hBC) and the state encoding (LOSS_SYNC=2'd0, ALIGN=2'd1, IN_SYNC=2'd2).
REQ-028 COM detection (valid_in && data_in==COM) SHALL be a sub-module com_detect; the FSM, counters and output registers stay in unstrip_ctrl.

Verification
REQ-029 Reset, then 4 valid BC -> active=1 after the 4th edge; no valid_out during alignment.
REQ-030 In sync, send 0x11,0x22,0x33 -> valid_out pulses with data_out 11/22/33 and lane_out 0/1/0, one cycle later.
REQ-031 In sync, send 0x11, BC, 0x22 -> lane_out 0 for 11, BC not forwarded, lane_out 0 for 22.
REQ-032 In ALIGN after 2 BC, send 0x55 -> state LOSS_SYNC; 4 more BC needed before active=1.
REQ-033 In sync, send 17 non-COM bytes without COM -> 16 forwarded, 17th dropped, active=0; with UNSTRIP_CTRL_ERRCNT_EN, err_cnt=1.
REQ-034 Assert reset_L=0 between clock edges mid-stream -> all outputs 0 immediately; valid_in gaps during sync hold lane_sel (0x11, gap, 0x22 -> lane_out 0 then 1).
